// File: rtl/axi4l_logger_ng.sv
// ---------------------------------------------------------------------------
// axi4l_logger_ng
// Passive AXI4-Lite transaction logger. It watches all five channels of one
// AXI4-Lite link and never drives the bus.
//
// A completed write (at the B handshake) or a completed read (at the R
// handshake) becomes a log record if its address lies in
// [ADDR_FROM, ADDR_TO] and log_en is high. A record holds the direction,
// address, data, strobe, response and timestamp. Records pass through one
// staging register per direction and are then pushed into a
// first-word-fall-through FIFO.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   log_en                enables recording (capture tracking always runs)
//   s_axi_aw*/w*/b*/ar*/r* sniffed AXI4-Lite channel signals
//   empty, r_req          FIFO empty flag and head pop request
//   r_rnw/addr/data/strb/resp/ts  head record fields (zero while empty)
//   count                 number of records held in the FIFO
//   drop_cnt              saturating count of records lost to staging overflow
//   protocol_err          sticky flag for handshake-order violations
// ---------------------------------------------------------------------------
module axi4l_logger_ng #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 64,
  parameter int                    TS_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] ADDR_FROM  = '0,
  parameter logic [ADDR_WIDTH-1:0] ADDR_TO    = '1,
  parameter int                    CNT_WIDTH  = 16,
  localparam int                   STRB_WIDTH = DATA_WIDTH / 8,
  localparam int                   PTR_WIDTH  = $clog2(DEPTH),
  localparam int                   FCNT_WIDTH = PTR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  log_en,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  input  logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  input  logic                  s_axi_wready,
  input  logic [1:0]            s_axi_bresp,
  input  logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                  s_axi_arvalid,
  input  logic                  s_axi_arready,
  input  logic [DATA_WIDTH-1:0] s_axi_rdata,
  input  logic [1:0]            s_axi_rresp,
  input  logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic                  empty,
  input  logic                  r_req,
  output logic                  r_rnw,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic [STRB_WIDTH-1:0] r_strb,
  output logic [1:0]            r_resp,
  output logic [TS_WIDTH-1:0]   r_ts,
  output logic [FCNT_WIDTH-1:0] count,
  output logic [CNT_WIDTH-1:0]  drop_cnt,
  output logic                  protocol_err
);

  typedef struct packed {
    logic                  rnw;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;
    logic [1:0]            resp;
    logic [TS_WIDTH-1:0]   ts;
  } rec_t;

  localparam logic [FCNT_WIDTH-1:0] FULL_CNT = FCNT_WIDTH'(DEPTH);

  // Window test done with subtract-and-borrow so that the default
  // full-range window does not become a constant comparison.
  function automatic logic in_window(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH:0] lo_diff;
    logic [ADDR_WIDTH:0] hi_diff;
    lo_diff = {1'b0, a} - {1'b0, ADDR_FROM};
    hi_diff = {1'b0, ADDR_TO} - {1'b0, a};
    return !lo_diff[ADDR_WIDTH] && !hi_diff[ADDR_WIDTH];
  endfunction

  logic [TS_WIDTH-1:0]   ts_q, ts_d;
  logic                  aw_got_q, aw_got_d, w_got_q, w_got_d, ar_got_q, ar_got_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                  wstg_vld_q, wstg_vld_d, rstg_vld_q, rstg_vld_d;
  rec_t                  wstg_q, wstg_d, rstg_q, rstg_d;
  logic                  rr_rd_q, rr_rd_d;
  logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FCNT_WIDTH-1:0] fcnt_q, fcnt_d;
  logic [CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;
  logic                  perr_q, perr_d;
  rec_t                  mem_q [DEPTH];

  logic aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;
  logic wr_cmp_s, rd_cmp_s, wr_ok_s, rd_ok_s, err_s;
  logic grant_wr_s, grant_rd_s, push_s, pop_s, full_s;
  logic wdrain_s, rdrain_s, wload_s, rload_s, wdrop_s, rdrop_s;
  logic [CNT_WIDTH:0] drop_sum_s;
  rec_t wr_rec_s, rd_rec_s, push_rec_s, head_s;

  assign aw_hs_s  = s_axi_awvalid && s_axi_awready;
  assign w_hs_s   = s_axi_wvalid  && s_axi_wready;
  assign b_hs_s   = s_axi_bvalid  && s_axi_bready;
  assign ar_hs_s  = s_axi_arvalid && s_axi_arready;
  assign r_hs_s   = s_axi_rvalid  && s_axi_rready;
  assign wr_cmp_s = b_hs_s && aw_got_q && w_got_q;
  assign rd_cmp_s = r_hs_s && ar_got_q;

  // A repeat capture is only legal when the same cycle's completion frees the slot.
  assign err_s = (b_hs_s && !(aw_got_q && w_got_q)) || (r_hs_s && !ar_got_q) ||
                 (aw_hs_s && aw_got_q && !wr_cmp_s) || (w_hs_s && w_got_q && !wr_cmp_s) ||
                 (ar_hs_s && ar_got_q && !rd_cmp_s);

  assign wr_rec_s = '{rnw: 1'b0, addr: awaddr_q, data: wdata_q, strb: wstrb_q,
                      resp: s_axi_bresp, ts: ts_q};
  assign rd_rec_s = '{rnw: 1'b1, addr: araddr_q, data: s_axi_rdata, strb: '0,
                      resp: s_axi_rresp, ts: ts_q};
  assign wr_ok_s  = wr_cmp_s && log_en && in_window(awaddr_q);
  assign rd_ok_s  = rd_cmp_s && log_en && in_window(araddr_q);

  // Round-robin grant between the staging registers; rr_rd_q=1 favours reads.
  always_comb begin
    grant_wr_s = 1'b0;
    grant_rd_s = 1'b0;
    if (wstg_vld_q && rstg_vld_q) begin
      grant_rd_s = rr_rd_q;
      grant_wr_s = !rr_rd_q;
    end else begin
      grant_wr_s = wstg_vld_q;
      grant_rd_s = rstg_vld_q;
    end
  end

  assign full_s     = (fcnt_q == FULL_CNT);
  assign pop_s      = r_req && !empty;
  assign push_s     = (grant_wr_s || grant_rd_s) && (!full_s || pop_s);
  assign push_rec_s = grant_wr_s ? wstg_q : rstg_q;
  assign wdrain_s   = grant_wr_s && push_s;
  assign rdrain_s   = grant_rd_s && push_s;
  assign wload_s    = wr_ok_s && (!wstg_vld_q || wdrain_s);
  assign rload_s    = rd_ok_s && (!rstg_vld_q || rdrain_s);
  assign wdrop_s    = wr_ok_s && !wload_s;
  assign rdrop_s    = rd_ok_s && !rload_s;
  assign drop_sum_s = {1'b0, drop_cnt_q} + (CNT_WIDTH+1)'(wdrop_s) + (CNT_WIDTH+1)'(rdrop_s);

  // Next-state logic for capture, staging, arbitration and FIFO bookkeeping.
  always_comb begin
    ts_d       = ts_q + TS_WIDTH'(1'b1);
    // Completion clears a flag first; a same-cycle handshake then sets it again.
    aw_got_d   = aw_hs_s ? 1'b1 : (wr_cmp_s ? 1'b0 : aw_got_q);
    w_got_d    = w_hs_s  ? 1'b1 : (wr_cmp_s ? 1'b0 : w_got_q);
    ar_got_d   = ar_hs_s ? 1'b1 : (rd_cmp_s ? 1'b0 : ar_got_q);
    awaddr_d   = aw_hs_s ? s_axi_awaddr : awaddr_q;
    wdata_d    = w_hs_s  ? s_axi_wdata  : wdata_q;
    wstrb_d    = w_hs_s  ? s_axi_wstrb  : wstrb_q;
    araddr_d   = ar_hs_s ? s_axi_araddr : araddr_q;
    perr_d     = perr_q | err_s;
    wstg_vld_d = wload_s ? 1'b1 : (wdrain_s ? 1'b0 : wstg_vld_q);
    rstg_vld_d = rload_s ? 1'b1 : (rdrain_s ? 1'b0 : rstg_vld_q);
    wstg_d     = wload_s ? wr_rec_s : wstg_q;
    rstg_d     = rload_s ? rd_rec_s : rstg_q;
    // Only a contended grant moves the round-robin pointer.
    rr_rd_d    = (wstg_vld_q && rstg_vld_q && push_s) ? grant_wr_s : rr_rd_q;
    wr_ptr_d   = push_s ? wr_ptr_q + PTR_WIDTH'(1'b1) : wr_ptr_q;
    rd_ptr_d   = pop_s  ? rd_ptr_q + PTR_WIDTH'(1'b1) : rd_ptr_q;
    fcnt_d     = fcnt_q + FCNT_WIDTH'(push_s) - FCNT_WIDTH'(pop_s);
    drop_cnt_d = drop_sum_s[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : drop_sum_s[CNT_WIDTH-1:0];
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q       <= '0;
      aw_got_q   <= 1'b0;
      w_got_q    <= 1'b0;
      ar_got_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      araddr_q   <= '0;
      perr_q     <= 1'b0;
      wstg_vld_q <= 1'b0;
      rstg_vld_q <= 1'b0;
      wstg_q     <= '0;
      rstg_q     <= '0;
      rr_rd_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fcnt_q     <= '0;
      drop_cnt_q <= '0;
    end else begin
      ts_q       <= ts_d;
      aw_got_q   <= aw_got_d;
      w_got_q    <= w_got_d;
      ar_got_q   <= ar_got_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      araddr_q   <= araddr_d;
      perr_q     <= perr_d;
      wstg_vld_q <= wstg_vld_d;
      rstg_vld_q <= rstg_vld_d;
      wstg_q     <= wstg_d;
      rstg_q     <= rstg_d;
      rr_rd_q    <= rr_rd_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fcnt_q     <= fcnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // FIFO storage; contents are don't-care until written, since reads are masked while empty.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= push_rec_s;
    end
  end

  assign empty        = (fcnt_q == '0);
  assign head_s       = empty ? '0 : mem_q[rd_ptr_q];
  assign r_rnw        = head_s.rnw;
  assign r_addr       = head_s.addr;
  assign r_data       = head_s.data;
  assign r_strb       = head_s.strb;
  assign r_resp       = head_s.resp;
  assign r_ts         = head_s.ts;
  assign count        = fcnt_q;
  assign drop_cnt     = drop_cnt_q;
  assign protocol_err = perr_q;

endmodule
